hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Pipeline control block sitting between the IF/ID latch and the ID/EX latch.
- Tracks pending register-file writes with a 32-entry scoreboard.
- Stalls fetch/decode and injects bubbles on read-after-write (RAW) and write-after-write (WAW) hazards, flushes on taken branches, and sequences HLT drain into a halted state.
- Exports a saturating stall-cycle counter for performance debug.

Parameters:
- NUM_REGS, 32, register-file entries tracked (address width fixed at 5).
- FLUSH_CYCLES, 2, cycles flush/bubble stay asserted after a taken branch (1..7).
- STALL_LIMIT, 255, consecutive stall cycles before stall_timeout asserts.

Ports:
- clock  in  1  rising-edge clock shared with decode stage.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF_ID holds a valid instruction.
- id_instr  in  32  IF_ID[31:0]: opcode [31:26], rs [25:21], rt [20:16], rd [15:11].
- wb_valid  in  1  writeback stage commits a register write this cycle.
- wb_addr  in  5  register written back.
- br_taken  in  1  execute stage resolved a taken BR/BNE.
- issue  out  1  instruction in ID advances into ID_EX this cycle.
- stall  out  1  hold PC and IF_ID.
- bubble  out  1  load NOP (control 16'h4000) into ID_EX.
- flush  out  1  invalidate IF_ID contents.
- halted  out  1  HLT drained; pipeline frozen.
- stall_timeout  out  1  stall run reached STALL_LIMIT (sticky until reset).
- stall_cycles  out  16  saturating count of stall cycles since reset.

Behaviour:
- Reset values (asynchronous, reset_n=0):
  - State RUN; busy vector 0; flush counter 0.
  - issue=0, stall=0, bubble=0, flush=0, halted=0, stall_timeout=0, stall_cycles=0.
- Opcode classes:
  - rd-writers, reading rs and rt: ADD 00, SUB 01, AND 05, OR 06, XOR 07, MUL 0C.
  - rd-writers, reading rs only: SHL 03, SHR 04, MOV 0A.
  - rt-writers: LI 02 (reads none); ADI 0B (reads rs).
  - Non-writers: BNE 09 (reads rs, rt); BR 08, HLT 0D, NOP 0E, and undefined opcodes 0F-3F (read none; undefined opcodes are treated as NOP).
- Hazard definition:
  - A register is a hazard if busy[r] & ~(wb_valid & wb_addr==r); the register file is write-first.
  - Hazard = any source register of the ID instruction, or its destination register (WAW), is a hazard.
- States and outputs:
  - RUN: if id_valid & ~hazard, then issue=1.
    - If the issued instruction is a writer, busy[dest] is set at the clock edge.
    - If the issued instruction is HLT, go to DRAIN.
    - If id_valid & hazard, stall=1, bubble=1, go to STALL.
  - STALL: stall=1, bubble=1 while the hazard persists. The cycle the hazard clears, issue as in RUN and return to RUN (zero extra cycles).
  - FLUSH: flush=1, bubble=1, stall=0 for FLUSH_CYCLES cycles, then RUN. No issue occurs and the scoreboard is not modified except by writeback.
  - DRAIN: stall=1, bubble=1 until busy==0, then HALTED.
  - HALTED: stall=1, bubble=1, halted=1. Exit only by reset.
- br_taken priority: br_taken in RUN or STALL overrides everything and enters FLUSH. An instruction in ID that cycle is not issued. br_taken is ignored in FLUSH (the counter is reloaded), DRAIN and HALTED.
- Simultaneous writeback and issue to the same register: busy stays 1 (the new writer wins).
- Writeback to a non-busy register: no effect.
- Counters:
  - stall_cycles increments each cycle stall=1 and saturates at 16'hFFFF.
  - The consecutive-stall counter resets on any cycle with stall=0.
  - stall_timeout sets when the consecutive-stall counter reaches STALL_LIMIT. It does not count in HALTED.
- Latency:
  - Combinational outputs (issue, stall, bubble, flush, halted) are derived from registered state plus inputs.
  - busy and state update at the rising clock edge.

Decomposition:
- Shared package pipe_pkg:
  - opcode localparams 6'h00..6'h0E;
  - one-hot control constants (NOP = 16'h4000);
  - state encoding RUN/STALL/FLUSH/DRAIN/HALTED;
  - instruction field bit positions.
- Sub-module reg_scoreboard: 32-bit busy vector with set port, clear port and set-wins rule. It outputs the busy vector; hazard evaluation stays in the top level.

Test Plan:
- RAW stall: issue ADD r5 with no writeback; next ID = SUB reading r5 → stall=1, bubble=1 each cycle. With wb_valid=1, wb_addr=5 → issue=1 in that same cycle and stall=0.
- WAW + same-cycle set/clear: issue LI to rt=7, then ADI to rt=7 in the same cycle as wb_valid, wb_addr=7 → ADI issues and busy[7] remains 1.
- Taken branch: br_taken=1 with a valid, hazard-free instruction in ID → issue=0, flush=1, bubble=1 for exactly 2 cycles, then RUN and issue resumes.
- HLT drain: busy[3]=1, issue HLT → stall=1, halted=0. Writeback r3 → halted=1 on the next cycle; further id_valid and br_taken are ignored.
- Timeout and counter: hold a hazard for 300 cycles with STALL_LIMIT=255 → stall_timeout rises on the 255th stall cycle and stall_cycles=300 at the end.
- Reset mid-operation: drop reset_n during FLUSH with busy≠0 → all outputs go to 0 and busy clears immediately, asynchronously, before the next clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg: opcodes, control words, sequencer states and instruction decode
// Rev 1.0
// ============================================================================
package pipe_pkg;

  localparam int REG_AW = 5;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h01;
  localparam logic [5:0] OP_LI  = 6'h02;
  localparam logic [5:0] OP_SHL = 6'h03;
  localparam logic [5:0] OP_SHR = 6'h04;
  localparam logic [5:0] OP_AND = 6'h05;
  localparam logic [5:0] OP_OR  = 6'h06;
  localparam logic [5:0] OP_XOR = 6'h07;
  localparam logic [5:0] OP_BR  = 6'h08;
  localparam logic [5:0] OP_BNE = 6'h09;
  localparam logic [5:0] OP_MOV = 6'h0A;
  localparam logic [5:0] OP_ADI = 6'h0B;
  localparam logic [5:0] OP_MUL = 6'h0C;
  localparam logic [5:0] OP_HLT = 6'h0D;
  localparam logic [5:0] OP_NOP = 6'h0E;

  // One-hot ID/EX control words: bit position equals the opcode value
  localparam logic [15:0] CTRL_ADD = 16'h0001;
  localparam logic [15:0] CTRL_BR  = 16'h0100;
  localparam logic [15:0] CTRL_HLT = 16'h2000;
  localparam logic [15:0] CTRL_NOP = 16'h4000;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_STALL  = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  typedef struct packed {
    logic              uses_rs;
    logic              uses_rt;
    logic              writes;
    logic [REG_AW-1:0] dest;
    logic              is_hlt;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d = '0;
    case (instr[OPC_HI:OPC_LO])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL: begin
        d.uses_rs = 1'b1;
        d.uses_rt = 1'b1;
        d.writes  = 1'b1;
        d.dest    = instr[RD_HI:RD_LO];
      end
      OP_SHL, OP_SHR, OP_MOV: begin
        d.uses_rs = 1'b1;
        d.writes  = 1'b1;
        d.dest    = instr[RD_HI:RD_LO];
      end
      OP_LI: begin
        d.writes = 1'b1;
        d.dest   = instr[RT_HI:RT_LO];
      end
      OP_ADI: begin
        d.uses_rs = 1'b1;
        d.writes  = 1'b1;
        d.dest    = instr[RT_HI:RT_LO];
      end
      OP_BNE: begin
        d.uses_rs = 1'b1;
        d.uses_rt = 1'b1;
      end
      OP_HLT:  d.is_hlt = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// reg_scoreboard: pending-write busy vector, a same-cycle set beats a clear
// Rev 1.0
// ============================================================================
module reg_scoreboard import pipe_pkg::*; #(
  parameter int NUM_REGS = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                set_en,
  input  logic [REG_AW-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= (busy & ~clr_mask) | set_mask;
  end

endmodule
`default_nettype wire

// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
// hazard_sequencer: ID-stage issue/stall/flush/halt control with stall stats
// Rev 1.0
// ============================================================================
module hazard_sequencer import pipe_pkg::*; #(
  parameter int NUM_REGS     = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_LIMIT  = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic              br_taken,
  output logic              issue,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic              halted,
  output logic              stall_timeout,
  output logic [15:0]       stall_cycles
);

  localparam int              RW      = $clog2(STALL_LIMIT + 1);
  localparam logic [2:0]      FL_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [RW-1:0]   RL_MAX  = RW'(STALL_LIMIT);
  localparam logic [RW-1:0]   RL_LAST = RW'(STALL_LIMIT - 1);

  state_t              state;
  logic [2:0]          flush_cnt;
  logic [RW-1:0]       run_len;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] busy_after_wb;
  dec_t                dec;
  logic [REG_AW-1:0]   rs;
  logic [REG_AW-1:0]   rt;
  logic                hazard;
  logic                run_like;
  logic                blocked;
  logic                take_br;
  logic                frozen;

  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask[wb_addr] = 1'b1;
  end

  // Write-first register file: a register retiring this cycle is already safe
  assign busy_after_wb = busy & ~wb_mask;
  assign dec           = decode(id_instr);
  assign rs            = id_instr[RS_HI:RS_LO];
  assign rt            = id_instr[RT_HI:RT_LO];
  assign hazard        = (dec.uses_rs & busy_after_wb[rs]) |
                         (dec.uses_rt & busy_after_wb[rt]) |
                         (dec.writes  & busy_after_wb[dec.dest]);

  // Outputs are gated by reset_n so they drop the instant reset asserts
  assign run_like = reset_n & ((state == ST_RUN) | (state == ST_STALL));
  assign frozen   = reset_n & ((state == ST_DRAIN) | (state == ST_HALTED));
  assign take_br  = run_like & br_taken;
  assign blocked  = run_like & ~br_taken & id_valid & hazard;
  assign issue    = run_like & ~br_taken & id_valid & ~hazard;
  assign stall    = blocked | frozen;
  assign flush    = reset_n & (state == ST_FLUSH);
  assign bubble   = blocked | take_br | flush | frozen;
  assign halted   = reset_n & (state == ST_HALTED);

  reg_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clock    (clock),
    .reset_n  (reset_n),
    .set_en   (issue & dec.writes),
    .set_addr (dec.dest),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .busy     (busy)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
    end else begin
      case (state)
        ST_RUN, ST_STALL: begin
          if (br_taken) begin
            state     <= ST_FLUSH;
            flush_cnt <= FL_LOAD;
          end else if (issue && dec.is_hlt) begin
            state <= ST_DRAIN;
          end else if (blocked) begin
            state <= ST_STALL;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (br_taken)              flush_cnt <= FL_LOAD;
          else if (flush_cnt == '0)  state     <= ST_RUN;
          else                       flush_cnt <= flush_cnt - 3'd1;
        end
        ST_DRAIN: begin
          if (busy_after_wb == '0) state <= ST_HALTED;
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

  // Halted cycles still count toward the total but not toward the timeout run
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles  <= '0;
      run_len       <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (stall && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
      if (!stall) begin
        run_len <= '0;
      end else if (state != ST_HALTED) begin
        if (run_len != RL_MAX)   run_len       <= run_len + RW'(1);
        if (run_len >= RL_LAST)  stall_timeout <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// tb_hazard_sequencer: random + directed stimulus against a queue-based model
// Rev 1.0
// ============================================================================
module tb_hazard_sequencer;

  localparam int FLUSH_CYCLES = 2;
  localparam int STALL_LIMIT  = 255;
  localparam int M_RUN = 0, M_FLUSH = 1, M_DRAIN = 2, M_HALT = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic        br_taken = 1'b0;
  logic        issue, stall, bubble, flush, halted, stall_timeout;
  logic [15:0] stall_cycles;

  hazard_sequencer #(
    .NUM_REGS(32), .FLUSH_CYCLES(FLUSH_CYCLES), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_instr(id_instr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .br_taken(br_taken),
    .issue(issue), .stall(stall), .bubble(bubble), .flush(flush),
    .halted(halted), .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit issue, stall, bubble, flush, halted, tmo;
    int cycles;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  // Reference model state
  bit mbusy[32];
  int mode, flush_left, total, run_len;
  bit tmo;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endfunction

  function automatic void model_reset();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    mode = M_RUN; flush_left = 0; total = 0; run_len = 0; tmo = 1'b0;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.issue = 0; e.stall = 0; e.bubble = 0; e.flush = 0; e.halted = 0; e.tmo = 0; e.cycles = 0;
    return e;
  endfunction

  function automatic exp_t model_step();
    exp_t e;
    int op, rs, rt, rd, dest, prev_mode;
    bit rd_rs, rd_rt, wr, haz, any_busy;
    bit busy_now[32];
    e = zero_exp();
    e.cycles = total; e.tmo = tmo;
    op = int'(id_instr[31:26]); rs = int'(id_instr[25:21]);
    rt = int'(id_instr[20:16]); rd = int'(id_instr[15:11]);
    rd_rs = 0; rd_rt = 0; wr = 0; dest = 0;
    if (op inside {0, 1, 5, 6, 7, 12})  begin rd_rs = 1; rd_rt = 1; wr = 1; dest = rd; end
    else if (op inside {3, 4, 10})      begin rd_rs = 1; wr = 1; dest = rd; end
    else if (op == 2)                   begin wr = 1; dest = rt; end
    else if (op == 11)                  begin rd_rs = 1; wr = 1; dest = rt; end
    else if (op == 9)                   begin rd_rs = 1; rd_rt = 1; end
    any_busy = 0;
    for (int i = 0; i < 32; i++) begin
      busy_now[i] = mbusy[i] && !(wb_valid && int'(wb_addr) == i);
      any_busy |= busy_now[i];
    end
    haz = (rd_rs && busy_now[rs]) || (rd_rt && busy_now[rt]) || (wr && busy_now[dest]);
    prev_mode = mode;
    case (mode)
      M_RUN: begin
        if (br_taken) begin e.bubble = 1; mode = M_FLUSH; flush_left = FLUSH_CYCLES; end
        else if (id_valid && !haz) begin e.issue = 1; if (op == 13) mode = M_DRAIN; end
        else if (id_valid) begin e.stall = 1; e.bubble = 1; end
      end
      M_FLUSH: begin
        e.flush = 1; e.bubble = 1;
        if (br_taken) flush_left = FLUSH_CYCLES;
        else begin flush_left--; if (flush_left == 0) mode = M_RUN; end
      end
      M_DRAIN: begin
        e.stall = 1; e.bubble = 1;
        if (!any_busy) mode = M_HALT;
      end
      default: begin e.stall = 1; e.bubble = 1; e.halted = 1; end
    endcase
    foreach (mbusy[i]) mbusy[i] = busy_now[i];
    if (e.issue && wr) mbusy[dest] = 1;
    if (e.stall) begin
      if (total < 65535) total++;
      if (prev_mode != M_HALT) begin run_len++; if (run_len >= STALL_LIMIT) tmo = 1; end
    end else begin
      run_len = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] mk(int op, int rs, int rt, int rd);
    return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  task automatic step(bit v, logic [31:0] ins, bit wv, int wa, bit br);
    @(posedge clock); #1;
    reset_n = 1; id_valid = v; id_instr = ins; wb_valid = wv; wb_addr = 5'(wa); br_taken = br;
    cyc++;
    expq.push_back(model_step());
  endtask

  task automatic hold_reset(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      reset_n = 0; id_valid = 1; id_instr = mk(0, 1, 2, 3); wb_valid = 0; br_taken = 0;
      cyc++;
      model_reset();
      expq.push_back(zero_exp());
    end
  endtask

  // Reset pulse between clock edges: outputs must drop and state clear without a clock
  task automatic pulse_reset(logic [31:0] ins);
    @(posedge clock); #1;
    id_valid = 1; id_instr = ins; wb_valid = 0; br_taken = 0; reset_n = 0;
    cyc++;
    #1;
    chk("async_rst_issue", int'(issue), 0);
    chk("async_rst_stall", int'(stall), 0);
    chk("async_rst_bubble", int'(bubble), 0);
    chk("async_rst_flush", int'(flush), 0);
    chk("async_rst_halted", int'(halted), 0);
    chk("async_rst_timeout", int'(stall_timeout), 0);
    chk("async_rst_cycles", int'(stall_cycles), 0);
    reset_n = 1;
    model_reset();
    expq.push_back(model_step());
  endtask

  task automatic rand_step(bit allow_hlt);
    int op;
    op = int'($urandom_range(0, 63));
    if (!allow_hlt && op == 13) op = 14;
    step($urandom_range(0, 3) != 0,
         mk(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7))),
         $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)), $urandom_range(0, 19) == 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("issue", int'(issue), int'(e.issue));
        chk("stall", int'(stall), int'(e.stall));
        chk("bubble", int'(bubble), int'(e.bubble));
        chk("flush", int'(flush), int'(e.flush));
        chk("halted", int'(halted), int'(e.halted));
        chk("stall_timeout", int'(stall_timeout), int'(e.tmo));
        chk("stall_cycles", int'(stall_cycles), e.cycles);
      end
    end
  end

  initial begin
    model_reset();
    hold_reset(2);
    // RAW on r5, cleared by a same-cycle writeback
    step(1, mk(0, 1, 2, 5), 0, 0, 0);
    repeat (3) step(1, mk(1, 5, 1, 6), 0, 0, 0);
    step(1, mk(1, 5, 1, 6), 1, 5, 0);
    // WAW on r7 with simultaneous set and clear, then a reader of r7
    step(1, mk(2, 0, 7, 0), 0, 0, 0);
    step(1, mk(11, 1, 7, 0), 1, 7, 0);
    step(1, mk(10, 7, 0, 8), 0, 0, 0);
    step(1, mk(10, 7, 0, 8), 1, 7, 0);
    // Taken branch with a clean instruction in ID
    step(1, mk(0, 1, 2, 3), 0, 0, 1);
    repeat (3) step(1, mk(0, 1, 2, 3), 0, 0, 0);
    // Branch re-asserted during flush
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    repeat (3) step(0, '0, 0, 0, 0);
    // Branch while stalled, then async reset in FLUSH with busy registers
    step(1, mk(0, 3, 1, 9), 0, 0, 0);
    step(1, mk(0, 3, 1, 9), 0, 0, 1);
    pulse_reset(mk(0, 3, 1, 9));
    step(0, '0, 0, 0, 0);
    // Random traffic
    repeat (1500) rand_step(1'b0);
    // HLT drain with r3 pending, then halted with ignored inputs until stall_cycles saturates
    hold_reset(1);
    step(1, mk(2, 0, 3, 0), 0, 0, 0);
    step(1, mk(13, 0, 0, 0), 0, 0, 0);
    repeat (3) step(1, mk(0, 1, 2, 4), 0, 0, 0);
    step(0, '0, 1, 3, 0);
    repeat (8) rand_step(1'b1);
    repeat (65600) step(1, mk(0, 1, 2, 4), 0, 0, $urandom_range(0, 1) == 1);
    // Long RAW stall crossing the timeout limit
    hold_reset(1);
    step(1, mk(0, 1, 2, 5), 0, 0, 0);
    repeat (300) step(1, mk(1, 5, 1, 6), 0, 0, 0);
    step(0, '0, 0, 0, 0);
    @(negedge clock); #1;
    chk("stall_cycles_after_300", int'(stall_cycles), 300);
    chk("timeout_after_300", int'(stall_timeout), 1);
    @(negedge clock);
    @(negedge clock);
    chk("scoreboard_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
